// File: rtl/addsub_seq_if.sv
// rtl/addsub_seq_if.sv - operand/result bundle for addsub_seq (ovf present with ADDSUB_SEQ_OVF_EN)
interface addsub_seq_if #(
  parameter int BITS  = 8,
  parameter int WORDS = 4
);
  localparam int N = BITS * WORDS;

  logic         start;
  logic         mode;
  logic         cin;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;
`ifdef ADDSUB_SEQ_OVF_EN
  logic         ovf;
`endif

  modport master (
    output start, mode, cin, x, y,
    input  busy, done, sum, cout
`ifdef ADDSUB_SEQ_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, mode, cin, x, y,
    output busy, done, sum, cout
`ifdef ADDSUB_SEQ_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/addsub_seq.sv
// rtl/addsub_seq.sv - multi-cycle slice-serial adder/subtractor; ADDSUB_SEQ_OVF_EN adds signed overflow output
module addsub_seq #(
  parameter int BITS  = 8,
  parameter int WORDS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  addsub_seq_if.slave  bus
);
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                      state_q, state_d;
  logic [WORDS-1:0][BITS-1:0]  x_q, x_d;
  logic [WORDS-1:0][BITS-1:0]  y_q, y_d;
  logic [WORDS-1:0][BITS-1:0]  sum_q, sum_d;
  logic                        mode_q, mode_d;
  logic                        carry_q, carry_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        cout_q, cout_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
`ifdef ADDSUB_SEQ_OVF_EN
  logic                        ovf_q, ovf_d;
  logic                        top_cin;
`endif

  logic [BITS-1:0]             slice_x;
  logic [BITS-1:0]             slice_y;
  logic [BITS:0]               slice_r;

  // Current slice: operand B is conditionally inverted so subtract is x + ~y + cin
  always_comb begin
    slice_x = x_q[idx_q];
    slice_y = y_q[idx_q] ^ {BITS{mode_q}};
    slice_r = {1'b0, slice_x} + {1'b0, slice_y} + {{BITS{1'b0}}, carry_q};
`ifdef ADDSUB_SEQ_OVF_EN
    // Carry into the slice MSB, recovered from the MSB sum bit
    top_cin = slice_r[BITS-1] ^ slice_x[BITS-1] ^ slice_y[BITS-1];
`endif
  end

  // Next-state and datapath update; busy/done are derived from the next state so they stay registered
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    sum_d   = sum_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    cout_d  = cout_q;
`ifdef ADDSUB_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          x_d     = bus.x;
          y_d     = bus.y;
          mode_d  = bus.mode;
          carry_d = bus.cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef ADDSUB_SEQ_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[idx_q] = slice_r[BITS-1:0];
        carry_d      = slice_r[BITS];
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_r[BITS];
`ifdef ADDSUB_SEQ_OVF_EN
          ovf_d   = top_cin ^ slice_r[BITS];
`endif
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      sum_q   <= '0;
      mode_q  <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ADDSUB_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sum_q   <= sum_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef ADDSUB_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef ADDSUB_SEQ_OVF_EN
  assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_addsub_seq.sv
// tb/tb_addsub_seq.sv - self-checking bench for addsub_seq (BITS=8, WORDS=4)
module tb_addsub_seq;
  localparam int BITS  = 8;
  localparam int WORDS = 4;
  localparam int N     = BITS * WORDS;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  addsub_seq_if #(.BITS(BITS), .WORDS(WORDS)) bus ();
  addsub_seq #(.BITS(BITS), .WORDS(WORDS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         m;
    logic         c;
    logic [N-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Whole-word reference: {ovf, cout, sum}
  function automatic logic [N+1:0] ref_op(input logic [N-1:0] x, input logic [N-1:0] y,
                                          input logic m, input logic c);
    logic [N-1:0] yb;
    logic [N:0]   t;
    logic         ov;
    yb = m ? ~y : y;
    t  = {1'b0, x} + {1'b0, yb} + {{N{1'b0}}, c};
    ov = (x[N-1] == yb[N-1]) && (t[N-1] != x[N-1]);
    return {ov, t[N], t[N-1:0]};
  endfunction

  // Called at a negedge; returns #1 after the accepting edge
  task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y, input logic m, input logic c);
    bus.x = x; bus.y = y; bus.mode = m; bus.cin = c; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // disturb: 0 quiet, 1 pulse start only, 2 scramble all inputs and pulse start
  task automatic wait_done(input int disturb, output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (bus.done) break;
      if (bus.busy !== 1'b1) begin
        n_vec++; n_bad++;
        $display("FAIL busy_in_run: got %b, expected 1 at cycle %0d", bus.busy, lat);
      end
      if (disturb == 2) begin
        bus.x = $urandom(); bus.y = $urandom(); bus.mode = 1'($urandom_range(0, 1));
        bus.cin = 1'($urandom_range(0, 1));
      end
      if (disturb != 0) bus.start = 1'($urandom_range(0, 1));
    end
    bus.start = 1'b0;
  endtask

  task automatic check_result(input string tag, input int lat, input logic [N-1:0] s,
                              input logic co, input logic ov);
    check({tag, ".latency"}, N'(lat), N'(WORDS + 1));
    check({tag, ".sum"}, bus.sum, s);
    check({tag, ".cout"}, N'(bus.cout), N'(co));
`ifdef ADDSUB_SEQ_OVF_EN
    check({tag, ".ovf"}, N'(bus.ovf), N'(ov));
`else
    if (ov === 1'bx) $display("unreachable");
`endif
  endtask

  task automatic check_hold(input string tag, input logic [N-1:0] s, input logic co);
    @(negedge clk);
    check({tag, ".done_pulse"}, N'(bus.done), N'(0));
    check({tag, ".busy_after"}, N'(bus.busy), N'(0));
    check({tag, ".sum_held"}, bus.sum, s);
    check({tag, ".cout_held"}, N'(bus.cout), N'(co));
  endtask

  initial begin
    int lat;
    int dones;
    logic [N+1:0] r;
    logic [N-1:0] rx, ry;
    logic rm, rc;

    tbl[0] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
    tbl[1] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[5] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[6] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
    tbl[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

    rst_n = 1'b0; bus.start = 1'b0; bus.mode = 1'b0; bus.cin = 1'b0; bus.x = '0; bus.y = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", N'(bus.busy), N'(0));
    check("reset.done", N'(bus.done), N'(0));
    check("reset.sum", bus.sum, '0);
    check("reset.cout", N'(bus.cout), N'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      issue(tbl[i].x, tbl[i].y, tbl[i].m, tbl[i].c);
      wait_done(0, lat);
      check_result($sformatf("tbl%0d", i), lat, tbl[i].s, tbl[i].co, tbl[i].ov);
      check_hold($sformatf("tbl%0d", i), tbl[i].s, tbl[i].co);
    end

    // Start pulses during RUN ignored, then back-to-back start in the DONE cycle
    issue(tbl[0].x, tbl[0].y, tbl[0].m, tbl[0].c);
    wait_done(1, lat);
    check_result("b2b.first", lat, tbl[0].s, tbl[0].co, tbl[0].ov);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    check("b2b.busy_next", N'(bus.busy), N'(1));
    check("b2b.done_next", N'(bus.done), N'(0));
    wait_done(0, lat);
    check_result("b2b.second", lat, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check_hold("b2b", 32'hFFFF_FFFF, 1'b1);

    // Operand hold: inputs scrambled every RUN cycle
    issue(tbl[1].x, tbl[1].y, tbl[1].m, tbl[1].c);
    wait_done(2, lat);
    check_result("hold", lat, tbl[1].s, tbl[1].co, tbl[1].ov);

    // Reset mid-RUN held two cycles
    @(negedge clk);
    issue(32'h0123_4567, 32'h0765_4321, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst.busy", N'(bus.busy), N'(0));
    check("midrst.done", N'(bus.done), N'(0));
    check("midrst.sum", bus.sum, '0);
    check("midrst.cout", N'(bus.cout), N'(0));
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("midrst.no_done", N'(dones), N'(0));

    // Reset wins over start in the same cycle
    rst_n = 1'b0;
    issue(32'h1, 32'h1, 1'b0, 1'b0);
    check("rstprio.busy", N'(bus.busy), N'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized operations against the whole-word model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: rx = 32'hFFFF_FFFF;
        1: rx = 32'h7FFF_FFFF;
        default: rx = $urandom();
      endcase
      ry = (i % 5 == 0) ? 32'h8000_0000 : $urandom();
      rm = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      r  = ref_op(rx, ry, rm, rc);
      issue(rx, ry, rm, rc);
      wait_done(int'($urandom_range(0, 2)), lat);
      check_result($sformatf("rnd%0d", i), lat, r[N-1:0], r[N], r[N+1]);
      if (i % 2 == 0) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
